// File: rtl/ball_collision_pkg.sv
// Shared geometry defaults, FSM state encoding and reset directions for the
// ball collision resolver.
package ball_collision_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = 11;

  localparam int SCREEN_W_DEF   = 320;
  localparam int SCREEN_H_DEF   = 240;
  localparam int BALL_SIZE_DEF  = 4;
  localparam int PLAT_Y_DEF     = 220;
  localparam int PLAT_THICK_DEF = 4;
  localparam int PLAT_SIZE_DEF  = 40;
  localparam int BRICK_TOP_DEF  = 16;
  localparam int BRICK_W_DEF    = 32;
  localparam int BRICK_H_DEF    = 8;
  localparam int BRICK_COLS_DEF = 10;
  localparam int BRICK_ROWS_DEF = 4;
  localparam int ADDR_W_DEF     = 6;

  localparam logic X_DU_RST = 1'b1;
  localparam logic Y_DU_RST = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WALL,
    PLAT,
    BRICK_REQ,
    BRICK_WAIT,
    DONE
  } state_t;

  // Zero-extend a screen coordinate so sums cannot wrap.
  function automatic logic [CALC_W-1:0] widen(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_collision_if.sv
// Brick memory port of the collision resolver: read request, response and
// clear strobe sharing one address.
interface ball_collision_if #(
  parameter int ADDR_W = ball_collision_pkg::ADDR_W_DEF
);

  logic              brick_rd;
  logic [ADDR_W-1:0] brick_addr;
  logic              brick_valid;
  logic              brick_rdata;
  logic              brick_clr;

  modport master (
    output brick_rd,
    output brick_addr,
    output brick_clr,
    input  brick_valid,
    input  brick_rdata
  );

  modport slave (
    input  brick_rd,
    input  brick_addr,
    input  brick_clr,
    output brick_valid,
    output brick_rdata
  );

endinterface

// File: rtl/ball_collision_brick_addr_calc.sv
// Maps a probe pixel to a brick memory address and flags whether the pixel
// lies inside the brick grid at all.
module brick_addr_calc import ball_collision_pkg::*; #(
  parameter int BRICK_TOP  = BRICK_TOP_DEF,
  parameter int BRICK_W    = BRICK_W_DEF,
  parameter int BRICK_H    = BRICK_H_DEF,
  parameter int BRICK_COLS = BRICK_COLS_DEF,
  parameter int BRICK_ROWS = BRICK_ROWS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic [CALC_W-1:0] px_i,
  input  logic [CALC_W-1:0] py_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  localparam logic [CALC_W-1:0] GRID_TOP   = CALC_W'(BRICK_TOP);
  localparam logic [CALC_W-1:0] GRID_BOT   = CALC_W'(BRICK_TOP + BRICK_ROWS * BRICK_H);
  localparam logic [CALC_W-1:0] GRID_RIGHT = CALC_W'(BRICK_COLS * BRICK_W);

  logic [CALC_W-1:0] row;
  logic [CALC_W-1:0] col;

  // Row/col are garbage when out of range; in_range_o gates their use.
  always_comb begin
    in_range_o = (py_i >= GRID_TOP) && (py_i < GRID_BOT) && (px_i < GRID_RIGHT);
    row        = (py_i - GRID_TOP) / CALC_W'(BRICK_H);
    col        = px_i / CALC_W'(BRICK_W);
    addr_o     = ADDR_W'(row * CALC_W'(BRICK_COLS) + col);
  end

endmodule

// File: rtl/ball_collision.sv
// Ball collision resolver: per move tick checks walls, platform and bricks and
// updates the direction bits. Define BOTTOM_BOUNCE_EN to bounce off the bottom.
module ball_collision import ball_collision_pkg::*; #(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int PLAT_Y     = PLAT_Y_DEF,
  parameter int PLAT_THICK = PLAT_THICK_DEF,
  parameter int PLAT_SIZE  = PLAT_SIZE_DEF,
  parameter int BRICK_TOP  = BRICK_TOP_DEF,
  parameter int BRICK_W    = BRICK_W_DEF,
  parameter int BRICK_H    = BRICK_H_DEF,
  parameter int BRICK_COLS = BRICK_COLS_DEF,
  parameter int BRICK_ROWS = BRICK_ROWS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] platx,
  output logic               x_du,
  output logic               y_du,
  output logic               plat_col,
  output logic               ball_lost,
  output logic               busy,
  output logic               done,
  ball_collision_if.master   brick_bus
);

  localparam logic [CALC_W-1:0] SCR_W    = CALC_W'(SCREEN_W);
  localparam logic [CALC_W-1:0] SCR_H    = CALC_W'(SCREEN_H);
  localparam logic [CALC_W-1:0] BALL     = CALC_W'(BALL_SIZE);
  localparam logic [CALC_W-1:0] BALL_MID = CALC_W'(BALL_SIZE / 2);
  localparam logic [CALC_W-1:0] PL_TOP   = CALC_W'(PLAT_Y);
  localparam logic [CALC_W-1:0] PL_BOT   = CALC_W'(PLAT_Y + PLAT_THICK);
  localparam logic [CALC_W-1:0] PL_LEN   = CALC_W'(PLAT_SIZE);

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  x_q, y_q, platx_q;
  logic                x_du_q, x_du_d;
  logic                y_du_q, y_du_d;
  logic                plat_col_q, plat_col_d;
  logic                ball_lost_q, ball_lost_d;
  logic                brick_rd_q, brick_rd_d;
  logic                brick_clr_q, brick_clr_d;
  logic [ADDR_W-1:0]   brick_addr_q, brick_addr_d;

  logic [CALC_W-1:0]   xs, ys, ps, x_end, y_end, probe_px, probe_py;
  logic                plat_hit, probe_top_skip, probe_in_range;
  logic [ADDR_W-1:0]   probe_addr;

  always_comb begin
    xs             = widen(x_q);
    ys             = widen(y_q);
    ps             = widen(platx_q);
    x_end          = xs + BALL;
    y_end          = ys + BALL;
    plat_hit       = y_du_q && (y_end >= PL_TOP) && (y_end < PL_BOT) &&
                     (x_end > ps) && (xs < ps + PL_LEN);
    probe_px       = xs + BALL_MID;
    probe_py       = y_du_q ? y_end : ys - CALC_W'(1);
    probe_top_skip = (y_q == '0) && !y_du_q;
  end

  brick_addr_calc #(
    .BRICK_TOP  (BRICK_TOP),
    .BRICK_W    (BRICK_W),
    .BRICK_H    (BRICK_H),
    .BRICK_COLS (BRICK_COLS),
    .BRICK_ROWS (BRICK_ROWS),
    .ADDR_W     (ADDR_W)
  ) u_addr_calc (
    .px_i       (probe_px),
    .py_i       (probe_py),
    .addr_o     (probe_addr),
    .in_range_o (probe_in_range)
  );

  // Position snapshot taken at the tick; stays put for the whole check.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && enable) begin
      x_q     <= x;
      y_q     <= y;
      platx_q <= platx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_du_q       <= X_DU_RST;
      y_du_q       <= Y_DU_RST;
      plat_col_q   <= 1'b0;
      ball_lost_q  <= 1'b0;
      brick_rd_q   <= 1'b0;
      brick_clr_q  <= 1'b0;
      brick_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      x_du_q       <= x_du_d;
      y_du_q       <= y_du_d;
      plat_col_q   <= plat_col_d;
      ball_lost_q  <= ball_lost_d;
      brick_rd_q   <= brick_rd_d;
      brick_clr_q  <= brick_clr_d;
      brick_addr_q <= brick_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_du_d       = x_du_q;
    y_du_d       = y_du_q;
    plat_col_d   = 1'b0;
    ball_lost_d  = 1'b0;
    brick_rd_d   = 1'b0;
    brick_clr_d  = 1'b0;
    brick_addr_d = brick_addr_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WALL;
      end
      WALL: begin
        if (x_q == '0)          x_du_d = 1'b1;
        else if (x_end >= SCR_W) x_du_d = 1'b0;
        if (y_q == '0)          y_du_d = 1'b1;
        if (y_end >= SCR_H) begin
`ifdef BOTTOM_BOUNCE_EN
          y_du_d  = 1'b0;
          state_d = PLAT;
`else
          ball_lost_d = 1'b1;
          state_d     = DONE;
`endif
        end else begin
          state_d = PLAT;
        end
      end
      PLAT: begin
        if (plat_hit) begin
          y_du_d     = 1'b0;
          plat_col_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = BRICK_REQ;
        end
      end
      BRICK_REQ: begin
        if (!probe_top_skip && probe_in_range) begin
          brick_addr_d = probe_addr;
          brick_rd_d   = 1'b1;
          state_d      = BRICK_WAIT;
        end else begin
          state_d = DONE;
        end
      end
      BRICK_WAIT: begin
        // A response in the request cycle itself cannot belong to this read.
        if (brick_bus.brick_valid && !brick_rd_q) begin
          if (brick_bus.brick_rdata) begin
            y_du_d      = ~y_du_q;
            brick_clr_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign x_du                 = x_du_q;
  assign y_du                 = y_du_q;
  assign plat_col             = plat_col_q;
  assign ball_lost            = ball_lost_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign brick_bus.brick_rd   = brick_rd_q;
  assign brick_bus.brick_clr  = brick_clr_q;
  assign brick_bus.brick_addr = brick_addr_q;

endmodule

// File: tb/tb_ball_collision.sv
// Directed bench for ball_collision: a chained table of ticks with hand-computed
// results, plus busy-enable and reset-during-read sequences.
module tb_ball_collision;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [9:0] x, y, platx;
  logic       x_du, y_du, plat_col, ball_lost, busy, done;

  ball_collision_if #(.ADDR_W(6)) bus();

  ball_collision dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .x         (x),
    .y         (y),
    .platx     (platx),
    .x_du      (x_du),
    .y_du      (y_du),
    .plat_col  (plat_col),
    .ball_lost (ball_lost),
    .busy      (busy),
    .done      (done),
    .brick_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x, y, platx, dly;
    bit    rdata;
    int    exp_lat, exp_rd, exp_addr, exp_clr, exp_plat, exp_lost;
    bit    exp_xdu, exp_ydu;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input string nm, input int vx, input int vy, input int vp,
                              input int dly, input bit rd, input int lat, input int nrd,
                              input int addr, input int clr, input int plat, input int lost,
                              input bit xd, input bit yd);
    vec_t v;
    v.name = nm; v.x = vx; v.y = vy; v.platx = vp; v.dly = dly; v.rdata = rd;
    v.exp_lat = lat; v.exp_rd = nrd; v.exp_addr = addr; v.exp_clr = clr;
    v.exp_plat = plat; v.exp_lost = lost; v.exp_xdu = xd; v.exp_ydu = yd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One tick: pulse enable, answer a read after v.dly cycles, then score it.
  task automatic run_vec(input vec_t v);
    int lat = -1, rd_n = -1, addr_rd = -1, addr_clr = -1;
    int rd_cnt = 0, clr_cnt = 0, plat_cnt = 0, lost_cnt = 0, done_cnt = 0, moves = 0;
    int busy0 = 0;
    x = 10'(v.x); y = 10'(v.y); platx = 10'(v.platx); enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; x = 10'd0; y = 10'd0; platx = 10'd0;
    for (int n = 0; n <= 40; n++) begin
      if (n == 0) busy0 = int'(busy);
      if (bus.brick_rd) begin
        rd_cnt++; rd_n = n; addr_rd = int'(bus.brick_addr);
      end else if (rd_n >= 0 && lat < 0 && int'(bus.brick_addr) != addr_rd) begin
        moves++;
      end
      if (bus.brick_clr) begin clr_cnt++; addr_clr = int'(bus.brick_addr); end
      if (plat_col)  plat_cnt++;
      if (ball_lost) lost_cnt++;
      if (done) begin done_cnt++; if (lat < 0) lat = n; end
      if (lat >= 0 && n >= lat + 2) break;
      bus.brick_valid = (n == 0) || (rd_n >= 0 && n == rd_n + v.dly);
      bus.brick_rdata = (rd_n >= 0 && n == rd_n + v.dly) ? v.rdata : 1'b1;
      @(posedge clk); #1;
    end
    bus.brick_valid = 1'b0; bus.brick_rdata = 1'b0;
    chk({v.name, ".latency"},   lat,      v.exp_lat);
    chk({v.name, ".done_cnt"},  done_cnt, 1);
    chk({v.name, ".busy"},      busy0,    1);
    chk({v.name, ".idle_busy"}, int'(busy), 0);
    chk({v.name, ".rd_cnt"},    rd_cnt,   v.exp_rd);
    if (v.exp_rd > 0) chk({v.name, ".rd_addr"}, addr_rd, v.exp_addr);
    chk({v.name, ".addr_hold"}, moves,    0);
    chk({v.name, ".clr_cnt"},   clr_cnt,  v.exp_clr);
    if (v.exp_clr > 0) chk({v.name, ".clr_addr"}, addr_clr, v.exp_addr);
    chk({v.name, ".plat_col"},  plat_cnt, v.exp_plat);
    chk({v.name, ".ball_lost"}, lost_cnt, v.exp_lost);
    chk({v.name, ".x_du"},      int'(x_du), int'(v.exp_xdu));
    chk({v.name, ".y_du"},      int'(y_du), int'(v.exp_ydu));
  endtask

  initial begin
    int dcnt, ccnt, bcnt, got_rd;
    reset = 1'b1; enable = 1'b0; x = '0; y = '0; platx = '0;
    bus.brick_valid = 1'b0; bus.brick_rdata = 1'b0;

    // Chained from reset direction x_du=1, y_du=0; each row's result seeds the next.
    //                 name              x    y    px  dly rd lat rd addr clr plat lost xdu ydu
    vecs[0]  = mk("right_wall",     316, 100,   0, 1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk("top_wall",       100,   0,   0, 1, 0, 3, 0,  0, 0, 0, 0, 0, 1);
    vecs[2]  = mk("brick_down",      38,  12,   0, 2, 1, 6, 1,  1, 1, 0, 0, 0, 0);
    vecs[3]  = mk("top_wall2",      100,   0,   0, 1, 0, 3, 0,  0, 0, 0, 0, 0, 1);
    vecs[4]  = mk("platform",       120, 216, 100, 1, 0, 2, 0,  0, 0, 1, 0, 0, 0);
    vecs[5]  = mk("brick_hit",       70,  40,   0, 3, 1, 7, 1, 22, 1, 0, 0, 0, 1);
    vecs[6]  = mk("platform2",      120, 216, 100, 1, 0, 2, 0,  0, 0, 1, 0, 0, 0);
    vecs[7]  = mk("corner_miss",      0,  40,   0, 1, 0, 5, 1, 20, 0, 0, 0, 1, 0);
    vecs[8]  = mk("top_wall3",      100,   0,   0, 1, 0, 3, 0,  0, 0, 0, 0, 1, 1);
    vecs[9]  = mk("plat_edge_miss",  96, 216, 100, 1, 0, 3, 0,  0, 0, 0, 0, 1, 1);
`ifdef BOTTOM_BOUNCE_EN
    vecs[10] = mk("bottom",         100, 236,   0, 1, 0, 3, 0,  0, 0, 0, 0, 1, 0);
`else
    vecs[10] = mk("bottom",         100, 236,   0, 1, 0, 1, 0,  0, 0, 0, 1, 1, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset.x_du",       int'(x_du), 1);
    chk("reset.y_du",       int'(y_du), 0);
    chk("reset.busy",       int'(busy), 0);
    chk("reset.done",       int'(done), 0);
    chk("reset.plat_col",   int'(plat_col), 0);
    chk("reset.ball_lost",  int'(ball_lost), 0);
    chk("reset.brick_rd",   int'(bus.brick_rd), 0);
    chk("reset.brick_clr",  int'(bus.brick_clr), 0);
    chk("reset.brick_addr", int'(bus.brick_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // A second tick while busy must not restart or re-latch the check.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; @(posedge clk); #1;
    x = 10'd316; y = 10'd100; platx = 10'd0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    x = 10'd0; y = 10'd0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("busy_enable.done_cnt", dcnt, 1);
    chk("busy_enable.x_du", int'(x_du), 0);

    // Reset while a read is outstanding, then a late response arrives.
    x = 10'd70; y = 10'd40; platx = 10'd0; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    got_rd = 0;
    for (int n = 0; n < 10 && got_rd == 0; n++) begin
      if (bus.brick_rd) got_rd = 1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_wait.rd_seen",   got_rd, 1);
    chk("rst_wait.rd_addr",   int'(bus.brick_addr), 22);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait.x_du",       int'(x_du), 1);
    chk("rst_wait.y_du",       int'(y_du), 0);
    chk("rst_wait.busy",       int'(busy), 0);
    chk("rst_wait.brick_rd",   int'(bus.brick_rd), 0);
    chk("rst_wait.brick_addr", int'(bus.brick_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.brick_valid = 1'b1; bus.brick_rdata = 1'b1;
    @(posedge clk); #1;
    bus.brick_valid = 1'b0; bus.brick_rdata = 1'b0;
    dcnt = 0; ccnt = 0; bcnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (done)          dcnt++;
      if (bus.brick_clr) ccnt++;
      if (busy)          bcnt++;
      @(posedge clk); #1;
    end
    chk("rst_wait.late_done", dcnt, 0);
    chk("rst_wait.late_clr",  ccnt, 0);
    chk("rst_wait.late_busy", bcnt, 0);
    chk("rst_wait.late_y_du", int'(y_du), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
